// File: rtl/dispatch.sv
// dispatch: Qu dispatch stage; allocates a ROB entry, marks the dest busy and hands the uop to the RS
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               rename handshake
//   in_op, in_dest                  uop opcode and destination tag
//   in_srcN_tag/busy/value          source tags with busy-table and RF reads
//   rob_tail_ptr, rob_full          ROB tail and allocation stall
//   rob_incr_tail_ptr               allocate the ROB entry at rob_tail_ptr
//   busy_set_en, busy_set_addr      mark the destination tag busy
//   retire_en/tag/value             retire broadcast, snooped for operand wakeup
//   rs_full, rs_wr_en               reservation station handshake
//   rs_op, rs_rob_addr, rs_dest     held uop fields
//   rs_srcN_tag/ready/value         held operands merged with the current retire snoop
//
// Build option QU_DISPATCH_RETIRE_BYPASS_EN: when defined, a retire matching a busy source
// in the accept cycle is captured directly; when undefined, accept stalls on any retire.
module dispatch #(
  parameter int PHY_RF_ADDR_WIDTH = 6,
  parameter int ROB_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [OP_WIDTH-1:0] in_op,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] in_dest,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] in_src1_tag,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] in_src2_tag,
  input  logic in_src1_busy,
  input  logic in_src2_busy,
  input  logic [DATA_WIDTH-1:0] in_src1_value,
  input  logic [DATA_WIDTH-1:0] in_src2_value,
  input  logic [ROB_ADDR_WIDTH-1:0] rob_tail_ptr,
  input  logic rob_full,
  output logic rob_incr_tail_ptr,
  output logic busy_set_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_set_addr,
  input  logic retire_en,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] retire_tag,
  input  logic [DATA_WIDTH-1:0] retire_value,
  input  logic rs_full,
  output logic rs_wr_en,
  output logic [OP_WIDTH-1:0] rs_op,
  output logic [ROB_ADDR_WIDTH-1:0] rs_rob_addr,
  output logic [PHY_RF_ADDR_WIDTH-1:0] rs_dest,
  output logic [PHY_RF_ADDR_WIDTH-1:0] rs_src1_tag,
  output logic rs_src1_ready,
  output logic [DATA_WIDTH-1:0] rs_src1_value,
  output logic [PHY_RF_ADDR_WIDTH-1:0] rs_src2_tag,
  output logic rs_src2_ready,
  output logic [DATA_WIDTH-1:0] rs_src2_value
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0] state;
  logic stage_valid;
  logic accept;
  logic stall;
  logic [OP_WIDTH-1:0] op_q;
  logic [ROB_ADDR_WIDTH-1:0] rob_q;
  logic [PHY_RF_ADDR_WIDTH-1:0] dest_q;
  logic [1:0][PHY_RF_ADDR_WIDTH-1:0] tag_q;
  logic [1:0] rdy_q;
  logic [1:0][DATA_WIDTH-1:0] val_q;
  logic [1:0][PHY_RF_ADDR_WIDTH-1:0] in_tag;
  logic [1:0] in_busy;
  logic [1:0][DATA_WIDTH-1:0] in_val;
  logic [1:0] snoop;
  logic [1:0] byp;
  logic [1:0] cap_rdy;
  logic [1:0][DATA_WIDTH-1:0] cap_val;
  assign stage_valid = state == HOLD;
`ifdef QU_DISPATCH_RETIRE_BYPASS_EN
  assign stall = 1'b0;
`else
  // without the accept-time bypass, let the busy table absorb the retire before reading it
  assign stall = retire_en;
`endif
  assign in_ready = !rst && !rob_full && (!stage_valid || !rs_full) && !stall;
  assign accept = in_valid && in_ready;
  assign rob_incr_tail_ptr = accept;
  assign busy_set_en = accept && |in_dest;
  assign busy_set_addr = busy_set_en ? in_dest : '0;
  assign rs_wr_en = !rst && stage_valid && !rs_full;
  assign in_tag = {in_src2_tag, in_src1_tag};
  assign in_busy = {in_src2_busy, in_src1_busy};
  assign in_val = {in_src2_value, in_src1_value};
  for (genvar s = 0; s < 2; s++) begin : g_src
    assign snoop[s] = stage_valid && retire_en && !rdy_q[s] && retire_tag == tag_q[s];
`ifdef QU_DISPATCH_RETIRE_BYPASS_EN
    assign byp[s] = retire_en && in_busy[s] && |in_tag[s] && retire_tag == in_tag[s];
`else
    assign byp[s] = 1'b0;
`endif
    // tag 0 is hardwired ready regardless of what the busy table reports
    assign cap_rdy[s] = byp[s] || !in_busy[s] || in_tag[s] == '0;
    assign cap_val[s] = byp[s] ? retire_value : in_val[s];
  end
  assign rs_op = op_q;
  assign rs_rob_addr = rob_q;
  assign rs_dest = dest_q;
  assign rs_src1_tag = tag_q[0];
  assign rs_src2_tag = tag_q[1];
  // merge the live snoop so a retire in the RS write cycle is not lost
  assign rs_src1_ready = rdy_q[0] || snoop[0];
  assign rs_src2_ready = rdy_q[1] || snoop[1];
  assign rs_src1_value = snoop[0] ? retire_value : val_q[0];
  assign rs_src2_value = snoop[1] ? retire_value : val_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      op_q <= '0;
      rob_q <= '0;
      dest_q <= '0;
      tag_q <= '0;
      rdy_q <= '0;
      val_q <= '0;
    end else begin
      state <= accept ? HOLD : rs_wr_en ? EMPTY : state;
      if (accept) begin
        op_q <= in_op | OP_WIDTH'(1);
        rob_q <= rob_tail_ptr;
        dest_q <= in_dest;
        tag_q <= in_tag;
        rdy_q <= cap_rdy;
        val_q <= cap_val;
      end else begin
        rdy_q <= rdy_q | snoop;
        for (int s = 0; s < 2; s++)
          val_q[s] <= snoop[s] ? retire_value : val_q[s];
      end
    end
  end
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: directed scoreboard bench for dispatch
module tb_dispatch;
  typedef struct packed {
    logic [7:0] op;
    logic [4:0] rob;
    logic [5:0] dest;
    logic [5:0] t1;
    logic r1;
    logic [31:0] v1;
    logic [5:0] t2;
    logic r2;
    logic [31:0] v2;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_op = '0;
  logic [5:0] in_dest = '0;
  logic [5:0] in_src1_tag = '0;
  logic [5:0] in_src2_tag = '0;
  logic in_src1_busy = 1'b0;
  logic in_src2_busy = 1'b0;
  logic [31:0] in_src1_value = '0;
  logic [31:0] in_src2_value = '0;
  logic [4:0] rob_tail_ptr = '0;
  logic rob_full = 1'b0;
  logic rob_incr_tail_ptr;
  logic busy_set_en;
  logic [5:0] busy_set_addr;
  logic retire_en = 1'b0;
  logic [5:0] retire_tag = '0;
  logic [31:0] retire_value = '0;
  logic rs_full = 1'b0;
  logic rs_wr_en;
  logic [7:0] rs_op;
  logic [4:0] rs_rob_addr;
  logic [5:0] rs_dest;
  logic [5:0] rs_src1_tag;
  logic rs_src1_ready;
  logic [31:0] rs_src1_value;
  logic [5:0] rs_src2_tag;
  logic rs_src2_ready;
  logic [31:0] rs_src2_value;
  int vectors = 0;
  int miscompares = 0;
  ent_t q[$];

  dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dest(in_dest), .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_busy(in_src1_busy), .in_src2_busy(in_src2_busy),
    .in_src1_value(in_src1_value), .in_src2_value(in_src2_value),
    .rob_tail_ptr(rob_tail_ptr), .rob_full(rob_full), .rob_incr_tail_ptr(rob_incr_tail_ptr),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .retire_en(retire_en),
    .retire_tag(retire_tag), .retire_value(retire_value), .rs_full(rs_full),
    .rs_wr_en(rs_wr_en), .rs_op(rs_op), .rs_rob_addr(rs_rob_addr), .rs_dest(rs_dest),
    .rs_src1_tag(rs_src1_tag), .rs_src1_ready(rs_src1_ready), .rs_src1_value(rs_src1_value),
    .rs_src2_tag(rs_src2_tag), .rs_src2_ready(rs_src2_ready), .rs_src2_value(rs_src2_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pops the scoreboard on every RS write seen mid-cycle, then advances to just after the next edge
  task automatic fin();
    ent_t g, e;
    if (rs_wr_en === 1'b1) begin
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL rs_unexpected_write got=1 exp=0");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        g = '{rs_op, rs_rob_addr, rs_dest, rs_src1_tag, rs_src1_ready, rs_src1_value,
              rs_src2_tag, rs_src2_ready, rs_src2_value};
        vectors++;
        assert (g === e) else begin
          miscompares++;
          $error("FAIL rs_entry got=%h exp=%h", g, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [5:0] dest,
                       input logic [5:0] t1, input logic b1, input logic [31:0] v1,
                       input logic [5:0] t2, input logic b2, input logic [31:0] v2,
                       input logic [4:0] tail);
    in_valid = v; in_op = op; in_dest = dest;
    in_src1_tag = t1; in_src1_busy = b1; in_src1_value = v1;
    in_src2_tag = t2; in_src2_busy = b2; in_src2_value = v2;
    rob_tail_ptr = tail;
  endtask

  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rs_wr_en", rs_wr_en, 0);
    fin();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {rob_incr_tail_ptr, busy_set_en, busy_set_addr, rs_wr_en, rs_op, rs_src1_ready, rs_src2_value}, 0);
    chk("idle_in_ready", in_ready, 1);
    fin();
    // basic accept
    drive(1, 8'h20, 7, 3, 0, 32'h11, 4, 0, 32'h22, 3);
    q.push_back('{8'h21, 5'd3, 6'd7, 6'd3, 1'b1, 32'h11, 6'd4, 1'b1, 32'h22});
    @(negedge clk);
    chk("acc_rob_incr", rob_incr_tail_ptr, 1);
    chk("acc_busy_set", {busy_set_en, busy_set_addr}, {1'b1, 6'd7});
    chk("acc_no_wr", rs_wr_en, 0);
    fin();
    in_valid = 0;
    @(negedge clk);
    chk("first_wr", rs_wr_en, 1);
    fin();
    // ROB full blocks acceptance
    rob_full = 1;
    drive(1, 8'h30, 8, 1, 0, 1, 2, 0, 2, 5);
    @(negedge clk);
    chk("robfull_ready", {in_ready, rob_incr_tail_ptr, busy_set_en}, 0);
    fin();
    rob_full = 0;
    // back-to-back with tail wrap; uop 2 has dest 0, uop 0 has busy tag 0
    for (int i = 0; i < 4; i++) begin
      logic [4:0] tail;
      tail = 5'(30 + i);
      drive(1, 8'(8'h40 + 2 * i), (i == 2) ? 6'd0 : 6'(10 + i), 0, 1, 32'(100 + i), 6'(20 + i), 0, 32'(200 + i), tail);
      q.push_back('{8'(8'h41 + 2 * i), tail, (i == 2) ? 6'd0 : 6'(10 + i), 6'd0, 1'b1, 32'(100 + i), 6'(20 + i), 1'b1, 32'(200 + i)});
      @(negedge clk);
      chk("b2b_ready", {in_ready, rob_incr_tail_ptr}, 2'b11);
      chk("b2b_busy_set", busy_set_en, i != 2);
      if (i > 0) chk("b2b_wr", rs_wr_en, 1);
      fin();
    end
    in_valid = 0;
    @(negedge clk);
    chk("b2b_last_wr", rs_wr_en, 1);
    fin();
    @(negedge clk);
    chk("b2b_drained", rs_wr_en, 0);
    fin();
    // snoop while held behind rs_full
    rs_full = 1;
    drive(1, 8'h50, 12, 0, 0, 5, 9, 1, 32'h77, 6);
    q.push_back('{8'h51, 5'd6, 6'd12, 6'd0, 1'b1, 32'h5, 6'd9, 1'b1, 32'hABCD});
    @(negedge clk);
    chk("hold_acc", in_ready, 1);
    fin();
    in_valid = 0;
    @(negedge clk);
    chk("hold_no_wr", {rs_wr_en, rs_src2_ready, in_ready}, 0);
    fin();
    retire_en = 1; retire_tag = 9; retire_value = 32'hABCD;
    @(negedge clk);
    chk("hold_merge", {rs_wr_en, rs_src2_ready, rs_src2_value}, {1'b0, 1'b1, 32'hABCD});
    fin();
    retire_en = 0; retire_value = 0; rs_full = 0;
    @(negedge clk);
    chk("hold_release_wr", rs_wr_en, 1);
    fin();
    // retire of a busy source in the accept cycle
    drive(1, 8'h60, 13, 5, 1, 32'h99, 0, 0, 32'h3, 8);
    retire_en = 1; retire_tag = 5; retire_value = 32'h42;
    q.push_back('{8'h61, 5'd8, 6'd13, 6'd5, 1'b1, 32'h42, 6'd0, 1'b1, 32'h3});
`ifdef QU_DISPATCH_RETIRE_BYPASS_EN
    @(negedge clk);
    chk("byp_ready", {in_ready, rob_incr_tail_ptr}, 2'b11);
    fin();
    retire_en = 0; in_valid = 0;
`else
    @(negedge clk);
    chk("stall_ready", {in_ready, rob_incr_tail_ptr, busy_set_en}, 0);
    fin();
    retire_en = 0; in_src1_busy = 0; in_src1_value = 32'h42;
    @(negedge clk);
    chk("stall_next_ready", {in_ready, rob_incr_tail_ptr}, 2'b11);
    fin();
    in_valid = 0;
`endif
    @(negedge clk);
    chk("byp_wr", rs_wr_en, 1);
    fin();
    // reset during HOLD discards the uop
    rs_full = 1;
    drive(1, 8'h70, 14, 1, 0, 1, 2, 0, 2, 9);
    @(negedge clk);
    chk("rsthold_acc", in_ready, 1);
    fin();
    in_valid = 0; rst = 1;
    @(negedge clk);
    chk("rsthold_outs", {rs_wr_en, in_ready, rob_incr_tail_ptr, busy_set_en}, 0);
    fin();
    rst = 0;
    @(negedge clk);
    chk("rsthold_empty", {dut.stage_valid, rs_wr_en, rs_op, rs_rob_addr}, 0);
    fin();
    rs_full = 0;
    @(negedge clk);
    chk("rsthold_no_wr", rs_wr_en, 0);
    fin();
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
